// File: rtl/multicycle_ctl_pkg.sv
// Shared opcode, funct3, state and instruction-class encodings for the
// multi-cycle control FSM.
package multicycle_ctl_pkg;

  typedef enum logic [6:0] {
    OP_R = 7'b0110011,
    OP_I = 7'b0010011,
    OP_S = 7'b0100011,
    OP_B = 7'b1100011,
    OP_J = 7'b1101111
  } opcode_e;

  typedef enum logic [2:0] {
    F3_ADD_SUB_BEQ = 3'b000,
    F3_LW_SW       = 3'b010
  } funct3_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_TRAP   = 3'd6
  } state_e;

  typedef enum logic [2:0] {
    CLS_R   = 3'd0,
    CLS_I   = 3'd1,
    CLS_LD  = 3'd2,
    CLS_ST  = 3'd3,
    CLS_BR  = 3'd4,
    CLS_J   = 3'd5,
    CLS_BAD = 3'd6
  } cls_e;

endpackage

// File: rtl/multicycle_ctl_if.sv
// Control/status bundle between the multi-cycle controller and the datapath.
interface multicycle_ctl_if;
  import multicycle_ctl_pkg::*;

  logic        run;
  opcode_e     opcode;
  funct3_e     funct3;
  logic        zero;
  logic        mem_ready;
  logic        mem_req;
  logic        mem_we;
  logic        mem_addr_sel;
  logic        ir_we;
  logic        pc_we;
  logic        pc_src;
  logic        alu_src_a;
  logic        alu_src_b;
  logic        rf_we;
  logic [1:0]  wb_sel;
  logic        retire;
  logic        trap;
  logic [2:0]  state;

  modport master (
    output run, opcode, funct3, zero, mem_ready,
    input  mem_req, mem_we, mem_addr_sel, ir_we, pc_we, pc_src,
           alu_src_a, alu_src_b, rf_we, wb_sel, retire, trap, state
  );

  modport slave (
    input  run, opcode, funct3, zero, mem_ready,
    output mem_req, mem_we, mem_addr_sel, ir_we, pc_we, pc_src,
           alu_src_a, alu_src_b, rf_we, wb_sel, retire, trap, state
  );
endinterface

// File: rtl/multicycle_ctl.sv
// Multi-cycle main control FSM: FETCH/DECODE/EXEC/MEM/WB sequencing with a
// memory-wait watchdog that parks the core in a sticky TRAP state.
module multicycle_ctl
  import multicycle_ctl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input logic             clk,
  input logic             rst_n,
  multicycle_ctl_if.slave bus
);

  localparam int unsigned CNT_W = 8;

  state_e           r_state;
  state_e           w_state_nxt;
  state_e           w_end_nxt;
  cls_e             r_cls;
  cls_e             w_cls_nxt;
  cls_e             w_cls_dec;
  logic [CNT_W-1:0] r_wait_cnt;
  logic             w_waiting;
  logic             w_timeout;

  logic       w_mem_req;
  logic       w_mem_we;
  logic       w_mem_addr_sel;
  logic       w_ir_we;
  logic       w_pc_we;
  logic       w_pc_src;
  logic       w_alu_src_a;
  logic       w_alu_src_b;
  logic       w_rf_we;
  logic [1:0] w_wb_sel;
  logic       w_retire;
  logic       w_trap;

  // Instruction class from the IR fields, only sampled in DECODE
  always_comb begin
    w_cls_dec = CLS_BAD;
    case (bus.opcode)
      OP_R: w_cls_dec = CLS_R;
      OP_I: w_cls_dec = (bus.funct3 == F3_LW_SW) ? CLS_LD : CLS_I;
      OP_S: if (bus.funct3 == F3_LW_SW)       w_cls_dec = CLS_ST;
      OP_B: if (bus.funct3 == F3_ADD_SUB_BEQ) w_cls_dec = CLS_BR;
      OP_J: w_cls_dec = CLS_J;
      default: w_cls_dec = CLS_BAD;
    endcase
  end

  // Counter holds the number of unacknowledged request cycles seen so far
  assign w_waiting = w_mem_req && !bus.mem_ready;
  assign w_timeout = w_waiting && (r_wait_cnt == CNT_W'(MEM_TIMEOUT - 1));
  assign w_end_nxt = bus.run ? ST_FETCH : ST_IDLE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_cls      <= CLS_BAD;
      r_wait_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_cls      <= w_cls_nxt;
      r_wait_cnt <= w_waiting ? (r_wait_cnt + CNT_W'(1)) : '0;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cls_nxt   = r_cls;
    case (r_state)
      ST_IDLE:  if (bus.run) w_state_nxt = ST_FETCH;
      ST_FETCH: begin
        if (bus.mem_ready)  w_state_nxt = ST_DECODE;
        else if (w_timeout) w_state_nxt = ST_TRAP;
      end
      ST_DECODE: begin
        w_cls_nxt   = w_cls_dec;
        w_state_nxt = (w_cls_dec == CLS_BAD) ? ST_TRAP : ST_EXEC;
      end
      ST_EXEC: begin
        case (r_cls)
          CLS_R, CLS_I:   w_state_nxt = ST_WB;
          CLS_LD, CLS_ST: w_state_nxt = ST_MEM;
          CLS_BR, CLS_J:  w_state_nxt = w_end_nxt;
          default:        w_state_nxt = ST_TRAP;
        endcase
      end
      ST_MEM: begin
        if (bus.mem_ready)  w_state_nxt = (r_cls == CLS_LD) ? ST_WB : w_end_nxt;
        else if (w_timeout) w_state_nxt = ST_TRAP;
      end
      ST_WB:   w_state_nxt = w_end_nxt;
      ST_TRAP: w_state_nxt = ST_TRAP;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Moore decode of state/class; ready and zero only qualify enables and retire
  always_comb begin
    w_mem_req      = 1'b0;
    w_mem_we       = 1'b0;
    w_mem_addr_sel = 1'b0;
    w_ir_we        = 1'b0;
    w_pc_we        = 1'b0;
    w_pc_src       = 1'b0;
    w_alu_src_a    = 1'b0;
    w_alu_src_b    = 1'b0;
    w_rf_we        = 1'b0;
    w_wb_sel       = 2'd0;
    w_retire       = 1'b0;
    w_trap         = 1'b0;
    case (r_state)
      ST_FETCH: begin
        w_mem_req = 1'b1;
        w_ir_we   = bus.mem_ready;
        w_pc_we   = bus.mem_ready;
      end
      ST_EXEC: begin
        case (r_cls)
          CLS_R: w_alu_src_a = 1'b1;
          CLS_I, CLS_LD, CLS_ST: begin
            w_alu_src_a = 1'b1;
            w_alu_src_b = 1'b1;
          end
          CLS_BR: begin
            w_alu_src_a = 1'b1;
            w_pc_src    = 1'b1;
            w_pc_we     = bus.zero;
            w_retire    = 1'b1;
          end
          CLS_J: begin
            w_pc_src = 1'b1;
            w_pc_we  = 1'b1;
            w_rf_we  = 1'b1;
            w_wb_sel = 2'd2;
            w_retire = 1'b1;
          end
          default: ;
        endcase
      end
      ST_MEM: begin
        w_mem_req      = 1'b1;
        w_mem_addr_sel = 1'b1;
        w_mem_we       = (r_cls == CLS_ST);
        w_retire       = (r_cls == CLS_ST) && bus.mem_ready;
      end
      ST_WB: begin
        w_rf_we  = 1'b1;
        w_wb_sel = (r_cls == CLS_LD) ? 2'd1 : 2'd0;
        w_retire = 1'b1;
      end
      ST_TRAP: w_trap = 1'b1;
      default: ;
    endcase
  end

  assign bus.mem_req      = w_mem_req;
  assign bus.mem_we       = w_mem_we;
  assign bus.mem_addr_sel = w_mem_addr_sel;
  assign bus.ir_we        = w_ir_we;
  assign bus.pc_we        = w_pc_we;
  assign bus.pc_src       = w_pc_src;
  assign bus.alu_src_a    = w_alu_src_a;
  assign bus.alu_src_b    = w_alu_src_b;
  assign bus.rf_we        = w_rf_we;
  assign bus.wb_sel       = w_wb_sel;
  assign bus.retire       = w_retire;
  assign bus.trap         = w_trap;
  assign bus.state        = 3'(r_state);

endmodule

// File: tb/tb_multicycle_ctl.sv
// Directed bench for multicycle_ctl: per-cycle control-word checks for each
// instruction class, memory waits, watchdog trap and asynchronous reset.
module tb_multicycle_ctl;
  import multicycle_ctl_pkg::*;

  // Control word: {mem_req, mem_we, mem_addr_sel, ir_we, pc_we, pc_src,
  //                alu_src_a, alu_src_b, rf_we, wb_sel[1:0], retire, trap, state[2:0]}
  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  multicycle_ctl_if bus ();

  multicycle_ctl #(.MEM_TIMEOUT(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  function automatic logic [15:0] outv();
    return {bus.mem_req, bus.mem_we, bus.mem_addr_sel, bus.ir_we, bus.pc_we,
            bus.pc_src, bus.alu_src_a, bus.alu_src_b, bus.rf_we, bus.wb_sel,
            bus.retire, bus.trap, bus.state};
  endfunction

  // Start an instruction from IDLE; the next negedge is its FETCH cycle
  task automatic go(input opcode_e op, input funct3_e f3);
    @(negedge clk);
    bus.opcode    = op;
    bus.funct3    = f3;
    bus.run       = 1'b1;
    bus.mem_ready = 1'b1;
    bus.zero      = 1'b0;
  endtask

  task automatic drain();
    bit seen;
    seen = 1'b0;
    @(negedge clk);
    bus.run       = 1'b0;
    bus.mem_ready = 1'b1;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      #1;
      if (bus.state === 3'd0) seen = 1'b1;
    end
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("FAIL drain_to_idle: state %0d, required 0 within 20 cycles", bus.state);
    end
  endtask

  task automatic test_reset();
    logic [15:0] got;
    rst_n         = 1'b0;
    bus.run       = 1'b1;
    bus.opcode    = OP_R;
    bus.funct3    = F3_ADD_SUB_BEQ;
    bus.zero      = 1'b1;
    bus.mem_ready = 1'b1;
    #3;
    got = outv();
    n_checks++;
    if (got !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_initial: got %04h required 0000", got);
    end
    repeat (2) @(negedge clk);
    #1;
    got = outv();
    n_checks++;
    if (got !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_held_run1: got %04h required 0000", got);
    end
    bus.run = 1'b0;
    rst_n   = 1'b1;
    @(negedge clk);
    #1;
    got = outv();
    n_checks++;
    if (got !== 16'h0000) begin
      n_fail++;
      $display("FAIL idle_run0: got %04h required 0000", got);
    end
  endtask

  task automatic test_r_type();
    logic [15:0] exp_v [5] = '{16'h9801, 16'h0002, 16'h0203, 16'h0095, 16'h9801};
    logic [15:0] got;
    go(OP_R, F3_ADD_SUB_BEQ);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.mem_ready = 1'b1;
      #1;
      got = outv();
      n_checks++;
      if (got !== exp_v[i]) begin
        n_fail++;
        $display("FAIL r_type cycle %0d: got %04h required %04h", i + 1, got, exp_v[i]);
      end
    end
    drain();
  endtask

  task automatic test_alu_imm();
    logic [15:0] exp_v [5] = '{16'h9801, 16'h0002, 16'h0303, 16'h0095, 16'h0000};
    bit          run_v [5] = '{1, 1, 1, 0, 0};
    logic [15:0] got;
    go(OP_I, F3_ADD_SUB_BEQ);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.run = run_v[i];
      #1;
      got = outv();
      n_checks++;
      if (got !== exp_v[i]) begin
        n_fail++;
        $display("FAIL alu_imm cycle %0d: got %04h required %04h", i + 1, got, exp_v[i]);
      end
    end
  endtask

  task automatic test_load_wait();
    logic [15:0] exp_v [9] = '{16'h9801, 16'h0002, 16'h0303, 16'hA004, 16'hA004,
                               16'hA004, 16'hA004, 16'h00B5, 16'h0000};
    bit          rdy   [9] = '{1, 1, 1, 0, 0, 0, 1, 1, 1};
    bit          run_v [9] = '{1, 1, 1, 1, 1, 1, 1, 0, 0};
    logic [15:0] got;
    go(OP_I, F3_LW_SW);
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      bus.mem_ready = rdy[i];
      bus.run       = run_v[i];
      #1;
      got = outv();
      n_checks++;
      if (got !== exp_v[i]) begin
        n_fail++;
        $display("FAIL load_wait cycle %0d: got %04h required %04h", i + 1, got, exp_v[i]);
      end
    end
  endtask

  task automatic test_branch();
    logic [15:0] exp_v [7] = '{16'h9801, 16'h0002, 16'h0E13, 16'h9801, 16'h0002,
                               16'h0613, 16'h0000};
    bit          zr    [7] = '{0, 0, 1, 1, 1, 0, 0};
    bit          run_v [7] = '{1, 1, 1, 1, 1, 0, 0};
    logic [15:0] got;
    go(OP_B, F3_ADD_SUB_BEQ);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      bus.zero = zr[i];
      bus.run  = run_v[i];
      #1;
      got = outv();
      n_checks++;
      if (got !== exp_v[i]) begin
        n_fail++;
        $display("FAIL branch cycle %0d: got %04h required %04h", i + 1, got, exp_v[i]);
      end
    end
  endtask

  task automatic test_jump();
    logic [15:0] exp_v [4] = '{16'h9801, 16'h0002, 16'h0CD3, 16'h0000};
    bit          run_v [4] = '{1, 1, 0, 0};
    logic [15:0] got;
    go(OP_J, F3_ADD_SUB_BEQ);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.run = run_v[i];
      #1;
      got = outv();
      n_checks++;
      if (got !== exp_v[i]) begin
        n_fail++;
        $display("FAIL jump cycle %0d: got %04h required %04h", i + 1, got, exp_v[i]);
      end
    end
  endtask

  task automatic test_store_run_drop();
    logic [15:0] exp_v [7] = '{16'h9801, 16'h0002, 16'h0303, 16'hE004, 16'hE014,
                               16'h0000, 16'h0000};
    bit          rdy   [7] = '{1, 1, 1, 0, 1, 1, 1};
    bit          run_v [7] = '{1, 0, 0, 0, 0, 0, 0};
    logic [15:0] got;
    go(OP_S, F3_LW_SW);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      bus.mem_ready = rdy[i];
      bus.run       = run_v[i];
      #1;
      got = outv();
      n_checks++;
      if (got !== exp_v[i]) begin
        n_fail++;
        $display("FAIL store_run_drop cycle %0d: got %04h required %04h", i + 1, got, exp_v[i]);
      end
    end
  endtask

  task automatic test_ready_at_timeout();
    logic [15:0] exp_v [8] = '{16'h8001, 16'h8001, 16'h8001, 16'h9801, 16'h0002,
                               16'h0203, 16'h0095, 16'h0000};
    bit          rdy   [8] = '{0, 0, 0, 1, 1, 1, 1, 1};
    bit          run_v [8] = '{1, 1, 1, 1, 0, 0, 0, 0};
    logic [15:0] got;
    go(OP_R, F3_ADD_SUB_BEQ);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      bus.mem_ready = rdy[i];
      bus.run       = run_v[i];
      #1;
      got = outv();
      n_checks++;
      if (got !== exp_v[i]) begin
        n_fail++;
        $display("FAIL ready_at_timeout cycle %0d: got %04h required %04h", i + 1, got, exp_v[i]);
      end
    end
  endtask

  task automatic test_async_reset_fetch();
    logic [15:0] got;
    go(OP_R, F3_ADD_SUB_BEQ);
    @(negedge clk);
    bus.mem_ready = 1'b0;
    #1;
    got = outv();
    n_checks++;
    if (got !== 16'h8001) begin
      n_fail++;
      $display("FAIL fetch_wait_before_reset: got %04h required 8001", got);
    end
    #2;
    rst_n = 1'b0;
    #1;
    got = outv();
    n_checks++;
    if (got !== 16'h0000) begin
      n_fail++;
      $display("FAIL async_reset_fetch: got %04h required 0000", got);
    end
    @(negedge clk);
    bus.run = 1'b0;
    rst_n   = 1'b1;
  endtask

  task automatic test_bad_opcode();
    logic [15:0] exp_v [5] = '{16'h9801, 16'h0002, 16'h000E, 16'h000E, 16'h000E};
    bit          run_v [5] = '{1, 1, 1, 0, 1};
    logic [15:0] got;
    go(OP_B, F3_LW_SW);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.run = run_v[i];
      #1;
      got = outv();
      n_checks++;
      if (got !== exp_v[i]) begin
        n_fail++;
        $display("FAIL bad_opcode cycle %0d: got %04h required %04h", i + 1, got, exp_v[i]);
      end
    end
    #2;
    rst_n = 1'b0;
    #1;
    got = outv();
    n_checks++;
    if (got !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_from_trap_decode: got %04h required 0000", got);
    end
    @(negedge clk);
    bus.run = 1'b0;
    rst_n   = 1'b1;
  endtask

  task automatic test_fetch_timeout();
    logic [15:0] exp_v [8] = '{16'h8001, 16'h8001, 16'h8001, 16'h8001, 16'h000E,
                               16'h000E, 16'h000E, 16'h000E};
    bit          run_v [8] = '{1, 1, 1, 1, 1, 0, 1, 0};
    logic [15:0] got;
    go(OP_R, F3_ADD_SUB_BEQ);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      bus.mem_ready = 1'b0;
      bus.run       = run_v[i];
      #1;
      got = outv();
      n_checks++;
      if (got !== exp_v[i]) begin
        n_fail++;
        $display("FAIL fetch_timeout cycle %0d: got %04h required %04h", i + 1, got, exp_v[i]);
      end
    end
    #2;
    rst_n = 1'b0;
    #1;
    got = outv();
    n_checks++;
    if (got !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_from_timeout_trap: got %04h required 0000", got);
    end
    @(negedge clk);
    bus.run = 1'b0;
    rst_n   = 1'b1;
    @(negedge clk);
    #1;
    got = outv();
    n_checks++;
    if (got !== 16'h0000) begin
      n_fail++;
      $display("FAIL idle_after_trap_reset: got %04h required 0000", got);
    end
  endtask

  initial begin
    test_reset();
    test_r_type();
    test_alu_imm();
    test_load_wait();
    test_branch();
    test_jump();
    test_store_run_drop();
    test_ready_at_timeout();
    test_async_reset_fetch();
    test_bad_opcode();
    test_fetch_timeout();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_ctl.md
Name: multicycle_ctl

Overview:
Multi-cycle main control FSM for the core. It sequences one instruction at a time through FETCH, DECODE, EXEC, MEM and WB. It drives the PC, IR and register-file write enables, the ALU operand selects and the memory request handshake. ALU_Ctl still generates ALU_Op combinationally from the IR fields; this block only chooses operands, controls writes and orders the steps.

Parameters:
MEM_TIMEOUT, 255, cycles mem_req may stay unacknowledged before the FSM traps (range 1..255, counter 8 bits).

Ports:
clk  input  1  core clock, rising edge
rst_n  input  1  asynchronous active-low reset
run  input  1  1 = start new instructions; 0 = stop at the next instruction boundary
opcode  input  opcode_e  opcode field of the IR
funct3  input  funct3_e  funct3 field of the IR
zero  input  1  ALU zero flag
mem_ready  input  1  memory acknowledge (read data valid or write accepted)
mem_req  output  1  memory request
mem_we  output  1  1 = store, 0 = read
mem_addr_sel  output  1  0 = PC, 1 = ALU result
ir_we  output  1  capture instruction into IR and current PC into pc_cur
pc_we  output  1  PC write enable
pc_src  output  1  0 = PC+4, 1 = pc_cur+imm
alu_src_a  output  1  0 = pc_cur, 1 = rs1
alu_src_b  output  1  0 = rs2, 1 = imm
rf_we  output  1  register-file write enable
wb_sel  output  2  0 = ALU, 1 = mem data, 2 = pc_cur+4, 3 = reserved
retire  output  1  one-cycle pulse when an instruction completes
trap  output  1  sticky error flag
state  output  3  IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, TRAP=6

Behaviour:
- Reset (async, rst_n=0): state=IDLE. All outputs are 0, the wait counter is 0 and trap is 0. Every output is a Moore decode of the state and the latched opcode, except the qualifiers listed per state, which are Mealy on mem_ready and zero.
- IDLE: go to FETCH when run=1, otherwise stay.
- FETCH: mem_req=1, mem_we=0, mem_addr_sel=0.
  - mem_ready=1: ir_we=1, pc_we=1, pc_src=0, then go to DECODE.
  - Otherwise: stay in FETCH and increment the wait counter.
- DECODE: one cycle, no writes. The FSM classifies the instruction from opcode/funct3:
  - OP_R: ALU instruction.
  - OP_I with funct3=F3_LW_SW: load.
  - OP_I otherwise: ALU-immediate.
  - OP_S with F3_LW_SW: store.
  - OP_B with F3_ADD_SUB_BEQ: branch.
  - OP_J: jump.
  - Anything else: go to TRAP. The class is latched into a register.
- EXEC: one cycle.
  - R: alu_src_a=1, alu_src_b=0, then WB.
  - I/load/store: alu_src_a=1, alu_src_b=1. I goes to WB; load and store go to MEM.
  - Branch: alu_src_a=1, alu_src_b=0. pc_src=1 and pc_we=zero. Then retire and go to END.
  - Jump: pc_src=1, pc_we=1, rf_we=1, wb_sel=2. Then retire and go to END.
- MEM: mem_req=1, mem_addr_sel=1, mem_we=1 for a store.
  - Hold mem_req, mem_we and mem_addr_sel stable until mem_ready.
  - On mem_ready: load goes to WB; store retires and goes to END.
- WB: one cycle. rf_we=1, wb_sel=1 for a load and 0 otherwise. Retire, then END.
- END (instruction boundary, not a state): next state is FETCH if run=1, else IDLE. No bubble is inserted between instructions.
- Latency with zero-wait memory:
  - Branch/jump: 3 cycles.
  - R/I/store: 4 cycles.
  - Load: 5 cycles.
  - Each memory wait cycle adds 1.
- Wait counter:
  - Cleared on entry to FETCH and to MEM, and on mem_ready.
  - Increments each cycle mem_req=1 and mem_ready=0.
  - When it reaches MEM_TIMEOUT with mem_ready still 0, go to TRAP. mem_ready in that same cycle wins over the timeout.
- TRAP: all enables and mem_req are 0, trap=1. Only reset leaves TRAP; run is ignored.
- retire asserts in the final cycle of each instruction.
- run deasserted mid-instruction: the instruction completes, then the FSM goes to IDLE.
- Asynchronous reset mid-memory-request: mem_req drops immediately.
- Reset in every state: the FSM goes to IDLE and all outputs clear within the reset assertion.

Test Plan:
- R-type ADD, run=1, mem_ready tied 1 → states 1,2,3,5. ir_we and pc_we in cycle 1, rf_we=1 with wb_sel=0 in cycle 4, retire in cycle 4, FETCH again in cycle 5.
- LW with mem_ready delayed 3 cycles in MEM → MEM lasts 4 cycles with mem_req/mem_addr_sel=1 stable. WB then has wb_sel=1 and rf_we=1. Total 8 cycles.
- BEQ with zero=1, then BEQ with zero=0 → pc_we=1 with pc_src=1 in EXEC for the first, pc_we=0 for the second. Both retire in cycle 3.
- OP_J → in EXEC: pc_we=1, pc_src=1, rf_we=1, wb_sel=2, retire=1. Cycle count 3.
- MEM_TIMEOUT=4 and mem_ready stuck 0 in FETCH → TRAP after 4 wait cycles, trap=1 and mem_req=0. Toggling run changes nothing; rst_n low returns the FSM to IDLE.
- SW, run dropped during DECODE → store completes with mem_we=1 in MEM and retire pulses, then state=IDLE. rst_n asserted mid-FETCH → all outputs 0 asynchronously.
